// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the dual-channel ADC packer: rate-divided sample strobe,
// 8-beat grouping with full checked only at group start, bounded/continuous runs.
module adc_capture_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             stop,
    input  logic             trig_en,
    input  logic             trig,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] num_words,
    input  logic             full,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] words_done,
    output logic [CNT_W-1:0] drop_cnt
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] num_lat_q, num_lat_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [2:0]       beat_q, beat_d;
    logic             grp_pass_q, grp_pass_d;
    logic             stop_pend_q, stop_pend_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic boundary_s, reached_s, term_s, strobe_s, pass_s;

    // Next-state and next-output computation for the whole sequencer
    always_comb begin
        state_d     = state_q;
        div_lat_d   = div_lat_q;
        div_cnt_d   = div_cnt_q;
        num_lat_d   = num_lat_q;
        words_d     = words_q;
        drop_d      = drop_q;
        beat_d      = beat_q;
        grp_pass_d  = grp_pass_q;
        stop_pend_d = stop_pend_q;
        ovf_d       = ovf_q;
        valid_d     = 1'b0;

        boundary_s = (beat_q == 3'd0);
        reached_s  = (num_lat_q != CNT_ZERO) && (words_q >= num_lat_q);
        // Termination is only legal between groups, and it suppresses any strobe that cycle
        term_s     = (state_q == CAPTURE) && boundary_s && (reached_s || stop_pend_q || stop);
        strobe_s   = (state_q == CAPTURE) && !term_s && (div_cnt_q == div_lat_q);
        pass_s     = boundary_s ? !full : grp_pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    div_lat_d   = div;
                    num_lat_d   = num_words;
                    words_d     = CNT_ZERO;
                    drop_d      = CNT_ZERO;
                    ovf_d       = 1'b0;
                    stop_pend_d = 1'b0;
                    beat_d      = 3'd0;
                    div_cnt_d   = DIV_ZERO;
                    grp_pass_d  = 1'b0;
                    state_d     = trig_en ? ARM : CAPTURE;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (stop) begin
                    state_d = DONE;
                end else if (trig) begin
                    div_cnt_d = DIV_ZERO;
                    state_d   = CAPTURE;
                end else begin
                    state_d = ARM;
                end
            end
            CAPTURE: begin
                if (term_s) begin
                    state_d = DONE;
                end else begin
                    stop_pend_d = stop_pend_q | stop;
                    if (strobe_s) begin
                        div_cnt_d = DIV_ZERO;
                        beat_d    = beat_q + 3'd1;
                        valid_d   = pass_s;
                        if (boundary_s) begin
                            grp_pass_d = !full;
                        end else begin
                            grp_pass_d = grp_pass_q;
                        end
                        if (pass_s && (beat_q == 3'd7) && (words_q != CNT_MAX)) begin
                            words_d = words_q + CNT_ONE;
                        end else begin
                            words_d = words_q;
                        end
                        if (boundary_s && full) begin
                            ovf_d  = 1'b1;
                            drop_d = (drop_q != CNT_MAX) ? drop_q + CNT_ONE : drop_q;
                        end else begin
                            ovf_d  = ovf_q;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ARM) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            div_lat_q   <= DIV_ZERO;
            div_cnt_q   <= DIV_ZERO;
            num_lat_q   <= CNT_ZERO;
            words_q     <= CNT_ZERO;
            drop_q      <= CNT_ZERO;
            beat_q      <= 3'd0;
            grp_pass_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_lat_q   <= div_lat_d;
            div_cnt_q   <= div_cnt_d;
            num_lat_q   <= num_lat_d;
            words_q     <= words_d;
            drop_q      <= drop_d;
            beat_q      <= beat_d;
            grp_pass_q  <= grp_pass_d;
            stop_pend_q <= stop_pend_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign valid      = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign words_done = words_q;
    assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: expected valid cycles and word counts are
// queued when a capture is started and popped as valid pulses appear.
module tb_adc_capture_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0, stop = 1'b0, trig_en = 1'b0, trig = 1'b0, full = 1'b0;
    logic [15:0] div = 16'd0;
    logic [23:0] num_words = 24'd0;
    logic        valid, busy, done, overflow;
    logic [23:0] words_done, drop_cnt;

    typedef struct {
        int          cyc;
        logic [23:0] wd;
    } exp_t;

    exp_t exp_q[$];
    exp_t ev;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    adc_capture_ctrl #(.DIV_W(16), .CNT_W(24)) dut (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .trig_en(trig_en),
        .trig(trig), .div(div), .num_words(num_words), .full(full),
        .valid(valid), .busy(busy), .done(done), .overflow(overflow),
        .words_done(words_done), .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Returns e = number of the first cycle after start is taken (first CAPTURE/ARM cycle)
    task automatic pulse_start(input logic [15:0] d, input logic [23:0] nw, input logic te, output int e);
        @(negedge CLK);
        div = d; num_words = nw; trig_en = te; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        e = cyc;
    endtask

    task automatic push_run(input int first, input int period, input int count);
        for (int k = 0; k < count; k++) exp_q.push_back('{cyc: first + k * period, wd: 24'((k + 1) / 8)});
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({valid, busy, done, overflow} !== 4'b0000 || words_done !== 24'd0 || drop_cnt !== 24'd0) begin
            n_err++;
            $display("FAIL reset: v/b/d/o=%b%b%b%b wd=%0d drop=%0d, required all 0", valid, busy, done, overflow, words_done, drop_cnt);
        end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_div0;
        int e, done_cyc;
        done_cyc = -1;
        pulse_start(16'd0, 24'd2, 1'b0, e);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: busy=%b, required 1", busy); end
        push_run(e + 1, 1, 16);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (valid !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL t1_extra_valid: valid=%b at offset %0d, required 0", valid, cyc - e);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || words_done !== ev.wd) begin
                        n_err++; $display("FAIL t1_valid: offset %0d wd %0d, required offset %0d wd %0d", cyc - e, words_done, ev.cyc - e, ev.wd);
                    end
                end
            end
            if (done === 1'b1) begin
                n_cmp++;
                if (done_cyc >= 0) begin
                    n_err++; $display("FAIL t1_done_width: done high again at offset %0d, required one pulse", cyc - e);
                end else begin
                    done_cyc = cyc;
                    if (busy !== 1'b0 || words_done !== 24'd2 || overflow !== 1'b0) begin
                        n_err++; $display("FAIL t1_done_state: busy=%b wd=%0d ovf=%b, required 0/2/0", busy, words_done, overflow);
                    end
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        n_cmp++;
        if (done_cyc != e + 17) begin n_err++; $display("FAIL t1_done_time: offset %0d, required 17", done_cyc - e); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL t1_missing: %0d valids missing, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_div3;
        int e, done_cyc;
        done_cyc = -1;
        pulse_start(16'd3, 24'd1, 1'b0, e);
        push_run(e + 4, 4, 8);
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (valid !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL t2_extra_valid: valid=%b at offset %0d, required 0", valid, cyc - e);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || words_done !== ev.wd) begin
                        n_err++; $display("FAIL t2_valid: offset %0d wd %0d, required offset %0d wd %0d", cyc - e, words_done, ev.cyc - e, ev.wd);
                    end
                end
            end
            if (done === 1'b1 && done_cyc < 0) begin
                done_cyc = cyc;
                n_cmp++;
                if (words_done !== 24'd1) begin n_err++; $display("FAIL t2_words: wd=%0d, required 1", words_done); end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        n_cmp++;
        if (done_cyc != e + 33) begin n_err++; $display("FAIL t2_done_time: offset %0d, required 33", done_cyc - e); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL t2_missing: %0d valids missing, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_drop;
        int e, done_cyc;
        done_cyc = -1;
        full = 1'b1;
        pulse_start(16'd0, 24'd3, 1'b0, e);
        push_run(e + 9, 1, 24);
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (valid !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL t3_extra_valid: valid=%b at offset %0d, required 0", valid, cyc - e);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || words_done !== ev.wd) begin
                        n_err++; $display("FAIL t3_valid: offset %0d wd %0d, required offset %0d wd %0d", cyc - e, words_done, ev.cyc - e, ev.wd);
                    end
                end
            end
            if (cyc == e + 1) begin
                full = 1'b0;
                n_cmp++;
                if (drop_cnt !== 24'd1 || overflow !== 1'b1) begin
                    n_err++; $display("FAIL t3_drop: drop=%0d ovf=%b, required 1/1", drop_cnt, overflow);
                end
            end
            if (done === 1'b1 && done_cyc < 0) begin
                done_cyc = cyc;
                n_cmp++;
                if (words_done !== 24'd3 || drop_cnt !== 24'd1 || overflow !== 1'b1) begin
                    n_err++; $display("FAIL t3_done_state: wd=%0d drop=%0d ovf=%b, required 3/1/1", words_done, drop_cnt, overflow);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        n_cmp++;
        if (done_cyc != e + 33) begin n_err++; $display("FAIL t3_done_time: offset %0d, required 33", done_cyc - e); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL t3_missing: %0d valids missing, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_stop_continuous;
        int e, done_cyc;
        done_cyc = -1;
        pulse_start(16'd0, 24'd0, 1'b0, e);
        push_run(e + 1, 1, 16);
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (valid !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL t4_extra_valid: valid=%b at offset %0d, required 0", valid, cyc - e);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || words_done !== ev.wd) begin
                        n_err++; $display("FAIL t4_valid: offset %0d wd %0d, required offset %0d wd %0d", cyc - e, words_done, ev.cyc - e, ev.wd);
                    end
                end
            end
            if (cyc == e + 11) stop = 1'b1;
            if (cyc == e + 12) stop = 1'b0;
            if (done === 1'b1 && done_cyc < 0) begin
                done_cyc = cyc;
                n_cmp++;
                if (words_done !== 24'd2 || busy !== 1'b0) begin
                    n_err++; $display("FAIL t4_done_state: wd=%0d busy=%b, required 2/0", words_done, busy);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
        end
        n_cmp++;
        if (done_cyc != e + 17) begin n_err++; $display("FAIL t4_done_time: offset %0d, required 17", done_cyc - e); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL t4_missing: %0d valids missing, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_trigger;
        int e, done_cyc;
        done_cyc = -1;
        trig = 1'b0;
        pulse_start(16'd0, 24'd1, 1'b1, e);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                n_err++; $display("FAIL t5_arm_wait: busy=%b valid=%b, required 1/0", busy, valid);
            end
        end
        trig = 1'b1;
        @(negedge CLK);
        trig = 1'b0;
        e = cyc;
        push_run(e + 1, 1, 8);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (valid !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL t5_extra_valid: valid=%b at offset %0d, required 0", valid, cyc - e);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || words_done !== ev.wd) begin
                        n_err++; $display("FAIL t5_valid: offset %0d wd %0d, required offset %0d wd %0d", cyc - e, words_done, ev.cyc - e, ev.wd);
                    end
                end
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        n_cmp++;
        if (done_cyc != e + 9) begin n_err++; $display("FAIL t5_done_time: offset %0d, required 9", done_cyc - e); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL t5_missing: %0d valids missing, required 0", exp_q.size()); end
        exp_q.delete();

        pulse_start(16'd0, 24'd1, 1'b1, e);
        repeat (3) @(negedge CLK);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || words_done !== 24'd0 || valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL t5_arm_stop: done=%b wd=%0d valid=%b busy=%b, required 1/0/0/0", done, words_done, valid, busy);
        end
        @(negedge CLK);
        n_cmp++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            n_err++; $display("FAIL t5_arm_stop_after: done=%b valid=%b, required 0/0", done, valid);
        end
        trig_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        int e, done_cyc;
        done_cyc = -1;
        pulse_start(16'd0, 24'd0, 1'b0, e);
        push_run(e + 1, 1, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (exp_q.size() == 0 || valid !== 1'b1) begin
                n_err++; $display("FAIL t6_pre_valid: valid=%b at offset %0d, required 1", valid, cyc - e);
            end else begin
                ev = exp_q.pop_front();
                if (cyc !== ev.cyc || words_done !== ev.wd) begin
                    n_err++; $display("FAIL t6_pre: offset %0d wd %0d, required offset %0d wd %0d", cyc - e, words_done, ev.cyc - e, ev.wd);
                end
            end
        end
        exp_q.delete();
        #1 RST = 1'b0;
        #1;
        n_cmp++;
        if ({valid, busy, done, overflow} !== 4'b0000 || words_done !== 24'd0 || drop_cnt !== 24'd0) begin
            n_err++; $display("FAIL t6_reset: v/b/d/o=%b%b%b%b wd=%0d drop=%0d, required all 0", valid, busy, done, overflow, words_done, drop_cnt);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        pulse_start(16'd0, 24'd1, 1'b0, e);
        push_run(e + 1, 1, 8);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (valid !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL t6_extra_valid: valid=%b at offset %0d, required 0", valid, cyc - e);
                end else begin
                    ev = exp_q.pop_front();
                    if (cyc !== ev.cyc || words_done !== ev.wd) begin
                        n_err++; $display("FAIL t6_valid: offset %0d wd %0d, required offset %0d wd %0d", cyc - e, words_done, ev.cyc - e, ev.wd);
                    end
                end
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        n_cmp++;
        if (done_cyc != e + 9 || words_done !== 24'd1) begin
            n_err++; $display("FAIL t6_done: offset %0d wd %0d, required 9/1", done_cyc - e, words_done);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL t6_missing: %0d valids missing, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_div0;
        test_div3;
        test_drop;
        test_stop_continuous;
        test_trigger;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
